// File: rtl/gc_lsu_pkg.sv
// Shared types and constants for the gc_lsu load/store unit.
// The GC_LSU_MISALIGN_EN macro, used by gc_lsu, enables split word-boundary accesses.
package gc_lsu_pkg;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned NL = DW / 8;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef struct packed {
        logic          we;
        size_e         size;
        logic          sext;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    // Right-justified load data to final width, sign- or zero-filled.
    function automatic logic [DW-1:0] extend_load(input logic [DW-1:0] h, input size_e s,
                                                  input logic sext);
        logic [DW-1:0] r;
        case (s)
            SZ_B:    r = {{(DW-8){sext & h[7]}}, h[7:0]};
            SZ_H:    r = {{(DW-16){sext & h[15]}}, h[15:0]};
            default: r = h;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gc_lsu_lane.sv
// Big-endian lane mapping: byte enables and aligned write data for one word phase,
// plus MSB-first collection of enabled read lanes into the holding value.
module gc_lsu_lane
    import gc_lsu_pkg::*;
(
    input  size_e         size,
    input  logic [1:0]    off,
    input  logic          phase,
    input  logic [DW-1:0] wd,
    input  logic [NL-1:0] rd_be,
    input  logic [DW-1:0] rd,
    input  logic [DW-1:0] hold,
    output logic [NL-1:0] be_c,
    output logic [DW-1:0] wd_c,
    output logic          span_c,
    output logic [DW-1:0] hold_c
);

    logic [2*NL-1:0] win_be;
    logic [2*DW-1:0] win_wd;

    // Two-word window: upper half is the first word, lower half the next word.
    always_comb begin
        win_be = '0;
        win_wd = '0;
        case (size)
            SZ_B: begin
                win_be = 8'b1000_0000;
                win_wd = {wd[7:0], 56'b0};
            end
            SZ_H: begin
                win_be = 8'b1100_0000;
                win_wd = {wd[15:0], 48'b0};
            end
            SZ_W: begin
                win_be = 8'b1111_0000;
                win_wd = {wd, 32'b0};
            end
            default: ;
        endcase
        win_be = win_be >> off;
        win_wd = win_wd >> {off, 3'b000};
        be_c   = phase ? win_be[NL-1:0] : win_be[2*NL-1:NL];
        wd_c   = phase ? win_wd[DW-1:0] : win_wd[2*DW-1:DW];
        span_c = |win_be[NL-1:0];
    end

    always_comb begin
        hold_c = hold;
        for (int i = NL - 1; i >= 0; i--) begin
            if (rd_be[i]) begin
                hold_c = {hold_c[DW-9:0], rd[8*i +: 8]};
            end
        end
    end

endmodule

// File: rtl/gc_lsu.sv
// Load/store unit in front of GC_mem: one request at a time, registered memory and response.
// Define GC_LSU_MISALIGN_EN to split word-boundary accesses over two memory cycles.
module gc_lsu
    import gc_lsu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_sext,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wd,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rd,
    output logic          rsp_err,
    output logic          mem_we,
    output logic [NL-1:0] mem_BE,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    state_e        state_q, state_d;
    req_t          req_q, req_d;
    logic          err_q, err_d;
    logic [DW-1:0] hold_q, hold_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_rd_q, rsp_rd_d;
    logic          rsp_err_q, rsp_err_d;
    logic          mem_we_q, mem_we_d;
    logic [NL-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wd_q, mem_wd_d;

    size_e         ln_size;
    logic [1:0]    ln_off;
    logic          ln_phase;
    logic [DW-1:0] ln_wd;
    logic [NL-1:0] ln_be;
    logic [DW-1:0] ln_wd_lane;
    logic          ln_span;
    logic [DW-1:0] ln_hold;
    logic          bad;
    logic          done;

    // Memory outputs are registered, so the lane map looks one phase ahead.
    always_comb begin
        if (state_q == ST_IDLE) begin
            ln_size  = size_e'(req_size);
            ln_off   = req_addr[1:0];
            ln_phase = 1'b0;
            ln_wd    = req_wd;
        end else begin
            ln_size  = req_q.size;
            ln_off   = req_q.addr[1:0];
            ln_phase = 1'b1;
            ln_wd    = req_q.wd;
        end
    end

    gc_lsu_lane u_lane (
        .size   (ln_size),
        .off    (ln_off),
        .phase  (ln_phase),
        .wd     (ln_wd),
        .rd_be  (mem_be_q),
        .rd     (mem_rd),
        .hold   (hold_q),
        .be_c   (ln_be),
        .wd_c   (ln_wd_lane),
        .span_c (ln_span),
        .hold_c (ln_hold)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        err_d       = err_q;
        hold_d      = hold_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wd_d    = '0;
        bad         = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = '{we: req_we, size: size_e'(req_size), sext: req_sext,
                              addr: req_addr, wd: req_wd};
`ifdef GC_LSU_MISALIGN_EN
                    bad = (req_size == 2'b11);
`else
                    bad = (req_size == 2'b11) || ln_span;
`endif
                    err_d       = bad;
                    hold_d      = '0;
                    req_ready_d = 1'b0;
                    state_d     = ST_ACC1;
                    if (!bad) begin
                        mem_we_d   = req_we;
                        mem_be_d   = ln_be;
                        mem_addr_d = {req_addr[AW-1:2], 2'b00};
                        mem_wd_d   = req_we ? ln_wd_lane : '0;
                    end
                end
            end
            ST_ACC1: begin
                hold_d = ln_hold;
`ifdef GC_LSU_MISALIGN_EN
                if (!err_q && ln_span) begin
                    state_d    = ST_ACC2;
                    mem_we_d   = req_q.we;
                    mem_be_d   = ln_be;
                    mem_addr_d = {(AW-2)'(req_q.addr[AW-1:2] + 1'b1), 2'b00};
                    mem_wd_d   = req_q.we ? ln_wd_lane : '0;
                end else begin
                    done = 1'b1;
                end
`else
                done = 1'b1;
`endif
            end
            ST_ACC2: begin
                hold_d = ln_hold;
                done   = 1'b1;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rd_d    = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Last access phase: finalize the response from the collected bytes.
        if (done) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rd_d    = (err_q || req_q.we) ? '0 : extend_load(ln_hold, req_q.size, req_q.sext);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rd_q    <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rd_q    <= rsp_rd_d;
            rsp_err_q   <= rsp_err_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rsp_rd_q;
    assign rsp_err   = rsp_err_q;
    assign mem_we    = mem_we_q;
    assign mem_BE    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_gc_lsu.sv
// Bench for gc_lsu: byte-addressed reference memory model, a GC_mem emulator,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_gc_lsu;
    import gc_lsu_pkg::*;

`ifdef GC_LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic          req_sext = 1'b0;
    logic [11:0]   req_addr = '0;
    logic [31:0]   req_wd = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rd;
    logic          rsp_err;
    logic          mem_we;
    logic [3:0]    mem_BE;
    logic [11:0]   mem_addr;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;

    always #5 clk = ~clk;

    gc_lsu dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr), .req_wd(req_wd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_we(mem_we), .mem_BE(mem_BE), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    // GC_mem emulator: word array, lane 3 holds the lowest byte address.
    logic [31:0] gmem [1024];
    logic [7:0]  ref_mem [4096];
    assign mem_rd = gmem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            for (int l = 0; l < 4; l++) begin
                if (mem_BE[l]) gmem[mem_addr[11:2]][8*l +: 8] <= mem_wd[8*l +: 8];
            end
        end
    end

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    bit          chk_en = 1'b0;
    bit          chk_rsp, chk_addr;
    logic        exp_req_ready, exp_rsp_valid, exp_rsp_err, exp_mem_we;
    logic [3:0]  exp_mem_be;
    logic [11:0] exp_mem_addr;
    logic [31:0] exp_rsp_rd, exp_mem_wd, exp_wd_mask;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(exp_req_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
            chk("mem_BE", 32'(mem_BE), 32'(exp_mem_be));
            if (chk_rsp) begin
                chk("rsp_rd", rsp_rd, exp_rsp_rd);
                chk("rsp_err", 32'(rsp_err), 32'(exp_rsp_err));
            end
            if (chk_addr) chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
            if (exp_wd_mask != 0) chk("mem_wd", mem_wd & exp_wd_mask, exp_mem_wd & exp_wd_mask);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int l = 0; l < 4; l++) if (be[l]) m[8*l +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic set_idle_exp();
        exp_req_ready = 1'b1; exp_rsp_valid = 1'b0; exp_mem_we = 1'b0; exp_mem_be = '0;
        chk_rsp = 1'b0; chk_addr = 1'b0; exp_wd_mask = '0;
        exp_rsp_rd = '0; exp_rsp_err = 1'b0; exp_mem_addr = '0; exp_mem_wd = '0;
    endtask

    task automatic set_reset_exp();
        set_idle_exp();
        chk_rsp = 1'b1; chk_addr = 1'b1; exp_wd_mask = 32'hFFFF_FFFF;
    endtask

    task automatic set_acc_exp(input logic we, input logic [3:0] be, input logic [11:0] a,
                               input logic [31:0] wd);
        exp_req_ready = 1'b0; exp_rsp_valid = 1'b0; chk_rsp = 1'b0;
        exp_mem_we = we; exp_mem_be = be; exp_mem_addr = a; exp_mem_wd = wd;
        chk_addr = (be != 0);
        exp_wd_mask = we ? lane_mask(be) : '0;
    endtask

    // Apply the store bytes that land in the first (first=1) or second word.
    task automatic commit(input logic [11:0] addr, input int n, input logic [31:0] wd,
                          input bit first);
        logic [11:0] b;
        for (int k = 0; k < n; k++) begin
            b = addr + 12'(k);
            if ((b[11:2] == addr[11:2]) == first) ref_mem[b] = wd[8*(n-1-k) +: 8];
        end
    endtask

    task automatic txn(input logic we, input logic [1:0] size, input logic sext,
                       input logic [11:0] addr, input logic [31:0] wd, input int wait_c,
                       input bit rst_acc1, output logic [31:0] got_rd, output logic got_err);
        int n, lane;
        bit span, err;
        logic [3:0] be1, be2;
        logic [31:0] wd1, wd2, val, exp_rd;
        logic [11:0] b;
        logic [9:0] w0;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
        span = (n != 0) && (int'(addr[1:0]) + n > 4);
        err = (size == 2'b11) || (span && !MIS);
        be1 = '0; be2 = '0; wd1 = '0; wd2 = '0;
        w0 = addr[11:2];
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                b = addr + 12'(k);
                lane = 3 - int'(b[1:0]);
                if (b[11:2] == w0) begin
                    be1[lane] = 1'b1; wd1[8*lane +: 8] = wd[8*(n-1-k) +: 8];
                end else begin
                    be2[lane] = 1'b1; wd2[8*lane +: 8] = wd[8*(n-1-k) +: 8];
                end
            end
        end
        val = '0;
        for (int k = 0; k < n; k++) val = (val << 8) | 32'(ref_mem[addr + 12'(k)]);
        if (sext && n > 0 && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 32'd1);
        exp_rd = (err || we) ? '0 : val;
        got_rd = '0;
        got_err = 1'b0;

        req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
        req_addr = addr; req_wd = wd;
        set_idle_exp();
        step();
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = 12'($urandom); req_wd = $urandom;

        set_acc_exp(we && !err, be1, {w0, 2'b00}, wd1);
        if (rst_acc1) begin
            rst_n = 1'b0;
            step();
            if (we && !err) commit(addr, n, wd, 1'b1);
            rst_n = 1'b1;
            set_reset_exp();
            step();
            set_idle_exp();
            return;
        end
        step();
        if (we && !err) commit(addr, n, wd, 1'b1);
        if (span && !err) begin
            set_acc_exp(we, be2, {w0 + 10'd1, 2'b00}, wd2);
            step();
            if (we) commit(addr, n, wd, 1'b0);
        end

        for (int i = 0; i <= wait_c; i++) begin
            set_idle_exp();
            exp_req_ready = 1'b0; exp_rsp_valid = 1'b1; chk_rsp = 1'b1;
            exp_rsp_rd = exp_rd; exp_rsp_err = err;
            rsp_ready = (i == wait_c);
            if (i == 0) begin
                #5;
                got_rd = rsp_rd;
                got_err = rsp_err;
            end
            step();
        end
        rsp_ready = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [1:0]  sz;
        logic [11:0] a;
        int          r;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom);
        ref_mem[4] = 8'h12;
        ref_mem[5] = 8'h34;
        for (int w = 0; w < 1024; w++)
            gmem[w] = {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};

        set_idle_exp();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        set_reset_exp();
        chk_en = 1'b1;
        step();
        set_idle_exp();

        txn(1'b1, 2'd2, 1'b0, 12'h010, 32'h1122_3344, 0, 1'b0, rd, er);
        txn(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 0, 1'b0, rd, er);
        chk("t1_load_word", rd, 32'h1122_3344);

        txn(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000_00AB, 1, 1'b0, rd, er);
        txn(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 0, 1'b0, rd, er);
        chk("t2_load_sext", rd, 32'hFFFF_FFAB);
        txn(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 2, 1'b0, rd, er);
        chk("t2_load_zext", rd, 32'h0000_00AB);

        txn(1'b1, 2'd1, 1'b0, 12'h006, 32'h0000_BEEF, 0, 1'b0, rd, er);
        txn(1'b0, 2'd1, 1'b0, 12'h006, 32'h0, 0, 1'b0, rd, er);
        chk("t3_load_half", rd, 32'h0000_BEEF);
        txn(1'b0, 2'd2, 1'b0, 12'h004, 32'h0, 0, 1'b0, rd, er);
        chk("t3_word_upper_kept", rd, 32'h1234_BEEF);

        txn(1'b1, 2'd2, 1'b0, 12'hFFE, 32'hCAFE_F00D, 0, 1'b0, rd, er);
        chk("t4_store_err", 32'(er), 32'(!MIS));
        txn(1'b0, 2'd2, 1'b0, 12'hFFE, 32'h0, 0, 1'b0, rd, er);
        chk("t4_load_span", MIS ? rd : 32'(er), MIS ? 32'hCAFE_F00D : 32'd1);

        txn(1'b0, 2'd3, 1'b0, 12'h020, 32'h0, 5, 1'b0, rd, er);
        chk("t5_illegal_err", 32'(er), 32'd1);
        chk("t5_illegal_rd", rd, 32'h0);

        txn(1'b1, 2'd2, 1'b0, 12'h021, 32'hA5A5_5A5A, 0, 1'b1, rd, er);
        txn(1'b1, 2'd2, 1'b0, 12'h030, 32'h0BAD_F00D, 0, 1'b0, rd, er);
        txn(1'b0, 2'd2, 1'b0, 12'h030, 32'h0, 0, 1'b0, rd, er);
        chk("t6_after_reset", rd, 32'h0BAD_F00D);
        txn(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 0, 1'b0, rd, er);

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = int'($urandom_range(0, 3));
            a = (r == 0) ? 12'($urandom_range(12'hFF8, 12'hFFF)) :
                (r == 1) ? 12'($urandom) : 12'($urandom_range(0, 63));
            txn(1'($urandom), sz, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                ($urandom_range(0, 19) == 0), rd, er);
            repeat (int'($urandom_range(0, 2))) step();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
